// File: rtl/m_mode_ctrl.sv
// m_mode_ctrl
//   Mode controller for the motor-drive select mux. Debounces the three
//   operator keys, runs the IDLE/MAN/AUTO/DEAD/FAULT state machine, inserts a
//   dead-time stop interval on every manual/automatic changeover and latches
//   a fault when the automatic heartbeat goes silent.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   key_man      raw manual key (async, 1 = pressed)
//   key_auto     raw automatic key (async, 1 = pressed)
//   key_stop     raw stop key (async, 1 = pressed)
//   estop        emergency stop level (synchronous, 1 = stop)
//   auto_hb      one-cycle heartbeat from the automatic controller
//   m_s          mux select: 10 manual, 01 auto, 00 stop
//   dead_active  high while in DEAD
//   fault        high while in FAULT
//   state        current state code
module m_mode_ctrl #(
  parameter int DEB_CYCLES  = 500000,
  parameter int DEAD_CYCLES = 250000,
  parameter int WDT_CYCLES  = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_man,
  input  logic       key_auto,
  input  logic       key_stop,
  input  logic       estop,
  input  logic       auto_hb,
  output logic [1:0] m_s,
  output logic       dead_active,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAN   = 3'd1,
    AUTO  = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_MAX = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDT_MAX  = CNT_W'(WDT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // Key vectors are indexed 0 = man, 1 = auto, 2 = stop.
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            deb_q, deb_d;
  logic [2:0]            deb_prev_q, deb_prev_d;
  logic [2:0]            press_q, press_d;
  logic [2:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  state_t                state_q, state_d;
  state_t                target_q, target_d;
  logic [CNT_W-1:0]      dead_cnt_q, dead_cnt_d;
  logic [CNT_W-1:0]      wdt_q, wdt_d;
  logic [1:0]            m_s_q, m_s_d;
  logic                  dead_active_q, dead_active_d;
  logic                  fault_q, fault_d;

  logic                  man_p, auto_p, stop_p;
  logic                  wdt_expire;

  // Key conditioning: synchroniser, debounce, registered rising-edge pulse.
  always_comb begin
    sync1_d    = {key_stop, key_auto, key_man};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_cnt_d  = deb_cnt_q;
    deb_prev_d = deb_q;
    press_d    = deb_q & ~deb_prev_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + ONE;
      end
    end
  end

  // Mode state machine, next-state and registered output values.
  always_comb begin
    man_p      = press_q[0];
    auto_p     = press_q[1];
    stop_p     = press_q[2];
    state_d    = state_q;
    target_d   = target_q;
    // A heartbeat in the expiry cycle rescues the watchdog.
    wdt_expire = (state_q == AUTO) && (wdt_q == WDT_MAX) && !auto_hb;

    if (estop) begin
      // FAULT is sticky through estop; everything else drops to IDLE.
      if (state_q != FAULT) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (man_p)       state_d = MAN;
          else if (auto_p) state_d = AUTO;
        end
        MAN: begin
          if (stop_p) state_d = IDLE;
          else if (auto_p) begin
            state_d  = DEAD;
            target_d = AUTO;
          end
        end
        AUTO: begin
          if (stop_p) state_d = IDLE;
          else if (man_p) begin
            state_d  = DEAD;
            target_d = MAN;
          end else if (wdt_expire) state_d = FAULT;
        end
        DEAD: begin
          if (stop_p) state_d = IDLE;
          else begin
            // Retarget without restarting the interval; man wins a tie.
            if (man_p)       target_d = MAN;
            else if (auto_p) target_d = AUTO;
            if (dead_cnt_q == DEAD_MAX) state_d = target_d;
          end
        end
        FAULT: begin
          if (stop_p) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if ((state_q == DEAD) && (state_d == DEAD) && (dead_cnt_q != DEAD_MAX))
      dead_cnt_d = dead_cnt_q + ONE;
    else
      dead_cnt_d = '0;

    if ((state_q == AUTO) && (state_d == AUTO) && !auto_hb)
      wdt_d = (wdt_q == WDT_MAX) ? wdt_q : wdt_q + ONE;
    else
      wdt_d = '0;

    m_s_d         = 2'b00;
    dead_active_d = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      MAN:     m_s_d         = 2'b10;
      AUTO:    m_s_d         = 2'b01;
      DEAD:    dead_active_d = 1'b1;
      FAULT:   fault_d       = 1'b1;
      default: m_s_d         = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_q         <= '0;
      deb_prev_q    <= '0;
      press_q       <= '0;
      deb_cnt_q     <= '0;
      state_q       <= IDLE;
      target_q      <= MAN;
      dead_cnt_q    <= '0;
      wdt_q         <= '0;
      m_s_q         <= 2'b00;
      dead_active_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      deb_prev_q    <= deb_prev_d;
      press_q       <= press_d;
      deb_cnt_q     <= deb_cnt_d;
      state_q       <= state_d;
      target_q      <= target_d;
      dead_cnt_q    <= dead_cnt_d;
      wdt_q         <= wdt_d;
      m_s_q         <= m_s_d;
      dead_active_q <= dead_active_d;
      fault_q       <= fault_d;
    end
  end

  assign m_s         = m_s_q;
  assign dead_active = dead_active_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_m_mode_ctrl.sv
// tb_m_mode_ctrl
//   Directed bench for m_mode_ctrl with short debounce/dead/watchdog times.
//   Key press latency: key set, 8th following edge shows the new state.
module tb_m_mode_ctrl;

  localparam int DEB  = 4;
  localparam int DEAD = 3;
  localparam int WDT  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_man, key_auto, key_stop, estop, auto_hb;
  logic [1:0] m_s;
  logic       dead_active, fault;
  logic [2:0] state;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] ms_prev;
  logic       swap_seen;

  m_mode_ctrl #(
    .DEB_CYCLES (DEB),
    .DEAD_CYCLES(DEAD),
    .WDT_CYCLES (WDT),
    .CNT_W      (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_man    (key_man),
    .key_auto   (key_auto),
    .key_stop   (key_stop),
    .estop      (estop),
    .auto_hb    (auto_hb),
    .m_s        (m_s),
    .dead_active(dead_active),
    .fault      (fault),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st,
                            input logic [1:0] ms, input logic da,
                            input logic f);
    check_val({tag, "_state"}, 32'(state), 32'(st));
    check_val({tag, "_m_s"}, 32'(m_s), 32'(ms));
    check_val({tag, "_dead"}, 32'(dead_active), 32'(da));
    check_val({tag, "_fault"}, 32'(fault), 32'(f));
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge and
  // tracking any direct 10 <-> 01 change of m_s.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if ((ms_prev == 2'b10 && m_s == 2'b01) || (ms_prev == 2'b01 && m_s == 2'b10))
        swap_seen = 1'b1;
      ms_prev = m_s;
    end
  endtask

  initial begin
    rst = 1'b1; key_man = 1'b0; key_auto = 1'b0; key_stop = 1'b0;
    estop = 1'b0; auto_hb = 1'b0;
    ms_prev = 2'b00; swap_seen = 1'b0;

    // Reset state
    step(2);
    check_outs("reset", 3'd0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);

    // 1: manual key held 10 clocks, MAN 7 clocks after first sampled edge
    key_man = 1'b1;
    step(7);
    check_val("man_latency_early", 32'(m_s), 32'(2'b00));
    step(1);
    check_outs("man_enter", 3'd1, 2'b10, 1'b0, 1'b0);
    step(2);
    key_man = 1'b0;
    step(8);
    check_val("man_release_hold", 32'(state), 32'd1);

    // 2: MAN -> DEAD (3 clocks of 00) -> AUTO
    key_auto = 1'b1;
    step(7);
    check_val("chg_before_dead", 32'(m_s), 32'(2'b10));
    step(1);
    check_outs("dead_c0", 3'd3, 2'b00, 1'b1, 1'b0);
    step(1);
    check_outs("dead_c1", 3'd3, 2'b00, 1'b1, 1'b0);
    step(1);
    check_outs("dead_c2", 3'd3, 2'b00, 1'b1, 1'b0);
    step(1);
    check_outs("auto_enter", 3'd2, 2'b01, 1'b0, 1'b0);
    check_val("no_direct_swap_1", 32'(swap_seen), 32'd0);
    key_auto = 1'b0;

    // 4: heartbeat every 6 clocks keeps AUTO alive
    for (int i = 0; i < 40; i++) begin
      auto_hb = (i % 6 == 0);
      step(1);
    end
    auto_hb = 1'b0;
    check_outs("auto_hb_alive", 3'd2, 2'b01, 1'b0, 1'b0);
    auto_hb = 1'b1;
    step(1);
    auto_hb = 1'b0;
    step(7);
    check_val("wdt_edge_still_auto", 32'(state), 32'd2);
    step(1);
    check_outs("wdt_fault", 3'd4, 2'b00, 1'b0, 1'b1);
    key_auto = 1'b1;
    step(10);
    check_outs("fault_ignores_auto", 3'd4, 2'b00, 1'b0, 1'b1);
    key_auto = 1'b0;
    step(8);
    key_stop = 1'b1;
    step(8);
    check_outs("fault_stop_idle", 3'd0, 2'b00, 1'b0, 1'b0);
    key_stop = 1'b0;
    step(8);

    // 3: 3-clock glitch on key_man produces no press
    key_man = 1'b1;
    step(3);
    key_man = 1'b0;
    step(15);
    check_outs("glitch_ignored", 3'd0, 2'b00, 1'b0, 1'b0);

    // 5a: retarget during DEAD keeps the original schedule
    key_man = 1'b1;
    step(8);
    check_val("t5_man", 32'(state), 32'd1);
    key_man = 1'b0;
    step(8);
    key_auto = 1'b1;
    step(2);
    key_man = 1'b1;      // its press lands in the second DEAD cycle
    step(6);
    check_val("t5_dead_entry", 32'(state), 32'd3);
    step(2);
    check_val("t5_dead_still", 32'(state), 32'd3);
    step(1);
    check_outs("t5_retarget_man", 3'd1, 2'b10, 1'b0, 1'b0);
    key_auto = 1'b0;
    key_man  = 1'b0;
    step(8);

    // 5b: estop during DEAD -> IDLE next clock, presses ignored under estop
    key_auto = 1'b1;
    step(8);
    check_val("t5_dead2", 32'(state), 32'd3);
    estop = 1'b1;
    step(1);
    check_outs("estop_idle", 3'd0, 2'b00, 1'b0, 1'b0);
    key_auto = 1'b0;
    step(8);
    key_man = 1'b1;
    step(10);
    check_outs("estop_ignores_man", 3'd0, 2'b00, 1'b0, 1'b0);
    key_man = 1'b0;
    step(8);
    estop = 1'b0;
    step(2);
    check_val("estop_release_idle", 32'(state), 32'd0);
    check_val("no_direct_swap_2", 32'(swap_seen), 32'd0);

    // 6: reset mid-watchdog in AUTO, then a fresh AUTO entry
    key_auto = 1'b1;
    step(8);
    check_val("t6_auto", 32'(state), 32'd2);
    key_auto = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    check_outs("t6_reset", 3'd0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    key_auto = 1'b1;
    step(8);
    check_outs("t6_auto_again", 3'd2, 2'b01, 1'b0, 1'b0);
    key_auto = 1'b0;
    step(7);
    check_outs("t6_wdt_fresh", 3'd2, 2'b01, 1'b0, 1'b0);
    step(1);
    check_val("t6_wdt_fault", 32'(fault), 32'd1);
    check_val("no_direct_swap_3", 32'(swap_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
